// File: rtl/config_window_gate_pkg.sv
// config_window_gate_pkg: shared state encoding and reject-counter constants
package config_window_gate_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, DRAIN = 2'd2, CLOSED = 2'd3} state_t;
  localparam int REJ_W = 8;
  localparam logic [REJ_W-1:0] REJ_MAX = '1;
  function automatic logic [REJ_W-1:0] sat_add(input logic [REJ_W-1:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = 16'(a) + b;
    return (s > 16'(REJ_MAX)) ? REJ_MAX : s[REJ_W-1:0];
  endfunction
endpackage

// File: rtl/config_window_gate_if.sv
// config_window_gate_if: request and downstream handshake bundle
interface config_window_gate_if #(parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  modport slave (input req_valid, req_data, out_ready, output req_ready, out_valid, out_data);
  modport master (output req_valid, req_data, out_ready, input req_ready, out_valid, out_data);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with extra-bit pointers and a same-edge flush
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic              w_push;
  logic              w_pop;
  assign empty  = r_wr == r_rd;
  assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign count  = r_wr - r_rd;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  // head word is held at zero while empty so idle output stays clean
  assign dout   = empty ? '0 : r_mem[r_rd[AW-1:0]];
  // pointer update; reset and flush both drop every buffered word
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  // storage write; contents past the pointers are don't-care
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/config_window_gate.sv
// config_window_gate: admits config words into a FIFO only while the countdown window is open (WINDOW_GATE_FLUSH_EN drops the backlog at window close)
module config_window_gate
  import config_window_gate_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MIN_TICKS = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  timeup_in,
  input  logic [7:0]            ticker_in,
  input  logic                  rearm_in,
  config_window_gate_if.slave   bus,
  output logic                  expired_out,
  output logic [REJ_W-1:0]      reject_count,
  output logic [1:0]            state_out
);
  state_t            r_state;
  logic              r_expired;
  logic [REJ_W-1:0]  r_rej;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic [DATA_W-1:0] w_dout;
  logic              w_xfer;
  logic              w_admit;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [15:0]       w_dropped;
  logic [15:0]       w_rej_add;
  assign bus.req_ready = !(r_state == OPEN && w_full);
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_dout;
  assign w_xfer        = bus.req_valid && bus.req_ready;
  assign w_admit       = (r_state == OPEN) && (ticker_in >= 8'(MIN_TICKS));
  assign w_push        = w_xfer && w_admit;
  assign w_pop         = bus.out_valid && bus.out_ready;
`ifdef WINDOW_GATE_FLUSH_EN
  assign w_flush       = (r_state == OPEN) && !timeup_in;
`else
  assign w_flush       = 1'b0;
`endif
  // a flush discards what is buffered plus any word entering on the same edge, minus one leaving
  assign w_dropped     = w_flush ? 16'(w_count) + 16'(w_push) - 16'(w_pop) : 16'd0;
  assign w_rej_add     = w_dropped + 16'(w_xfer && !w_admit);
  assign expired_out   = r_expired;
  assign reject_count  = r_rej;
  assign state_out     = r_state;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset_in),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (bus.req_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );
  // window FSM with sticky expired flag and saturating reject counter
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state   <= IDLE;
      r_expired <= 1'b0;
      r_rej     <= '0;
    end else begin
      r_rej <= sat_add(r_rej, w_rej_add);
      case (r_state)
        IDLE:   if (timeup_in) r_state <= OPEN;
        OPEN:   if (!timeup_in) r_state <= DRAIN;
        DRAIN:  if (w_empty) begin
          r_state   <= CLOSED;
          r_expired <= 1'b1;
        end
        CLOSED: if (rearm_in) begin
          r_state   <= IDLE;
          r_expired <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_config_window_gate.sv
// tb_config_window_gate: scoreboard bench for the window gate
module tb_config_window_gate;
  logic        clk = 0;
  logic        reset_in = 1;
  logic        timeup_in = 0;
  logic [7:0]  ticker_in = 0;
  logic        rearm_in = 0;
  logic        expired_out;
  logic [7:0]  reject_count;
  logic [1:0]  state_out;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q [$];

  config_window_gate_if #(.DATA_W(32)) bus ();

  config_window_gate #(.DATA_W(32), .DEPTH(4), .MIN_TICKS(1)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .timeup_in    (timeup_in),
    .ticker_in    (ticker_in),
    .rearm_in     (rearm_in),
    .bus          (bus),
    .expired_out  (expired_out),
    .reject_count (reject_count),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit admit);
    bus.req_valid = 1;
    bus.req_data  = d;
    if (admit) q.push_back(d);
    for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
    chk("req_ready_wait", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    tick();
  endtask

  // monitor: every accepted output word must match the next expected word
  initial forever begin
    @(negedge clk);
    if (!reset_in && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data unexpected: got %h, required no output at %0t", bus.out_data, $time);
      end else chk("out_data", bus.out_data, q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0;
    bus.req_data  = 0;
    bus.out_ready = 0;
    tick();
    tick();
    reset_in = 0;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_expired", 32'(expired_out), 0);
    chk("rst_reject", 32'(reject_count), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    // basic admission with downstream always ready
    timeup_in = 1;
    ticker_in = 10;
    bus.out_ready = 1;
    tick();
    chk("open_state", 32'(state_out), 1);
    send(32'hA1, 1);
    send(32'hA2, 1);
    send(32'hA3, 1);
    wait_drain();
    chk("basic_reject", 32'(reject_count), 0);
    chk("basic_state", 32'(state_out), 1);
    // backpressure: FIFO fills at 4, fifth word waits
    bus.out_ready = 0;
    send(32'hB0, 1);
    send(32'hB1, 1);
    send(32'hB2, 1);
    send(32'hB3, 1);
    chk("full_req_ready", 32'(bus.req_ready), 0);
    chk("full_out_valid", 32'(bus.out_valid), 1);
    chk("full_head", bus.out_data, 32'hB0);
    bus.req_valid = 1;
    bus.req_data  = 32'hB4;
    q.push_back(32'hB4);
    tick();
    tick();
    chk("held_req_ready", 32'(bus.req_ready), 0);
    bus.out_ready = 1;
    for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
    chk("unblock_req_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 0;
    wait_drain();
    // ticker below minimum discards
    ticker_in = 0;
    send(32'h55, 0);
    tick();
    chk("low_tick_reject", 32'(reject_count), 1);
    chk("low_tick_out_valid", 32'(bus.out_valid), 0);
    ticker_in = 10;
    // window close with three buffered words
    bus.out_ready = 0;
`ifdef WINDOW_GATE_FLUSH_EN
    send(32'hC1, 0);
    send(32'hC2, 0);
    send(32'hC3, 0);
    timeup_in = 0;
    tick();
    chk("flush_state_d", 32'(state_out), 2);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    tick();
    chk("flush_state_c", 32'(state_out), 3);
    chk("flush_reject", 32'(reject_count), 4);
    bus.out_ready = 1;
`else
    send(32'hC1, 1);
    send(32'hC2, 1);
    send(32'hC3, 1);
    timeup_in = 0;
    bus.out_ready = 1;
    tick();
    chk("drain_state_0", 32'(state_out), 2);
    tick();
    chk("drain_state_1", 32'(state_out), 2);
    tick();
    chk("drain_state_2", 32'(state_out), 2);
    tick();
    chk("drain_state_c", 32'(state_out), 3);
    chk("drain_reject", 32'(reject_count), 1);
`endif
    chk("closed_expired", 32'(expired_out), 1);
    chk("closed_out_valid", 32'(bus.out_valid), 0);
    chk("closed_queue", q.size(), 0);
    // rejects saturate while closed; a rising timeup cannot reopen
    timeup_in = 1;
    bus.req_valid = 1;
    bus.req_data  = 32'h99;
    repeat (300) tick();
    bus.req_valid = 0;
    chk("sat_reject", 32'(reject_count), 255);
    chk("closed_hold", 32'(state_out), 3);
    rearm_in = 1;
    tick();
    rearm_in = 0;
    chk("rearm_state", 32'(state_out), 0);
    chk("rearm_expired", 32'(expired_out), 0);
    tick();
    chk("reopen_state", 32'(state_out), 1);
    rearm_in = 1;
    tick();
    rearm_in = 0;
    chk("rearm_ignored", 32'(state_out), 1);
    // reset mid-operation discards buffered words
    bus.out_ready = 0;
    send(32'hD1, 0);
    send(32'hD2, 0);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_reject", 32'(reject_count), 255);
    reset_in = 1;
    tick();
    reset_in = 0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_reject", 32'(reject_count), 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    bus.out_ready = 1;
    repeat (5) tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
